// File: rtl/fg_ctrl_pkg.sv
// Shared encodings for the front-panel parameter editor: select codes and repeat-FSM states.
package fg_ctrl_pkg;

  localparam logic [1:0] SEL_WAVE = 2'd0;
  localparam logic [1:0] SEL_FREQ = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_MAX  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } rpt_state_t;

  function automatic logic [1:0] next_sel(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, then a level that changes only after
// DEBOUNCE_TICKS consecutive sample ticks disagree with it; o_rise pulses with a new high level.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= 1'b0;
      // Any agreeing sample restarts the stability count.
      if (i_tick) begin
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/param_edit_ctrl.sv
// Parameter editor: mode button cycles sel, up/down emit inc/dec strobes (and step wave_sel).
// Define AUTO_REPEAT_EN to get hold-to-repeat strobes; otherwise one strobe per press.
module param_edit_ctrl #(
  parameter int CLK_DIV        = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  output logic [1:0] sel,
  output logic       min_or_max,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic [1:0] wave_sel,
  output logic       busy
);

  import fg_ctrl_pkg::*;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_T = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RPT_LD   = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  rpt_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir_up;
  logic [1:0]       r_sel;
  logic             r_mom;
  logic             r_inc;
  logic             r_dec;
  logic [1:0]       r_wave;
  logic             r_busy;

  logic             w_up_lvl, w_up_rise;
  logic             w_dn_lvl, w_dn_rise;
  logic             w_mode_lvl, w_mode_rise;
  rpt_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_strobe;
  logic             w_abort;

  // Sample-tick generator shared by all three debouncers and the repeat timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
    .clock(clock), .reset_n(reset_n), .i_tick(r_tick), .i_btn(btn_up),
    .o_level(w_up_lvl), .o_rise(w_up_rise)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dn (
    .clock(clock), .reset_n(reset_n), .i_tick(r_tick), .i_btn(btn_down),
    .o_level(w_dn_lvl), .o_rise(w_dn_rise)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
    .clock(clock), .reset_n(reset_n), .i_tick(r_tick), .i_btn(btn_mode),
    .o_level(w_mode_lvl), .o_rise(w_mode_rise)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir_up;
    w_strobe    = 1'b0;
    // A session ends when its own button drops or the opposite one comes in.
    w_abort     = r_dir_up ? (!w_up_lvl || w_dn_lvl) : (!w_dn_lvl || w_up_lvl);
    case (r_state)
      ST_IDLE: begin
        if (w_up_rise && !w_dn_lvl) begin
          w_state_nxt = ST_FIRST;
          w_dir_nxt   = 1'b1;
        end else if (w_dn_rise && !w_up_lvl) begin
          w_state_nxt = ST_FIRST;
          w_dir_nxt   = 1'b0;
        end
      end
      ST_FIRST: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_strobe    = 1'b1;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tick && r_cnt != '0) begin
          if (AUTO_RPT && r_cnt == CNT_ONE) begin
            w_strobe    = 1'b1;
            w_cnt_nxt   = RPT_LD;
            w_state_nxt = ST_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tick) begin
          if (r_cnt <= CNT_ONE) begin
            w_strobe  = 1'b1;
            w_cnt_nxt = RPT_LD;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dir_up <= 1'b0;
      r_busy   <= 1'b0;
      r_inc    <= 1'b0;
      r_dec    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_up <= w_dir_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_inc    <= w_strobe && r_dir_up;
      r_dec    <= w_strobe && !r_dir_up;
    end
  end

  // Mode edges only count while no up/down session is active.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel  <= SEL_WAVE;
      r_mom  <= 1'b0;
      r_wave <= 2'd0;
    end else begin
      if (r_state == ST_IDLE && w_mode_rise) begin
        r_sel <= next_sel(r_sel);
        r_mom <= (next_sel(r_sel) == SEL_MAX);
      end
      if (w_strobe && r_sel == SEL_WAVE) begin
        r_wave <= r_dir_up ? (r_wave + 2'd1) : (r_wave - 2'd1);
      end
    end
  end

  assign sel        = r_sel;
  assign min_or_max = r_mom;
  assign inc_pulse  = r_inc;
  assign dec_pulse  = r_dec;
  assign wave_sel   = r_wave;
  assign busy       = r_busy;

endmodule

// File: tb/tb_param_edit_ctrl.sv
// Bench for param_edit_ctrl: directed scenarios plus random button sessions scored by a tick-level model.
`timescale 1ns/1ps
module tb_param_edit_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int HOLD    = 8;
  localparam int RPT     = 2;
  localparam int SETTLE  = (DEB + 4) * CLK_DIV;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] sel;
  logic       min_or_max;
  logic       inc_pulse;
  logic       dec_pulse;
  logic [1:0] wave_sel;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_inc = 0;
  int n_dec = 0;
  bit both_seen = 1'b0;
  int inc_t[$];

  int m_sel  = 0;
  int m_wave = 0;

  int b_i, b_d, s0, bad, first_ok, n, op, h, k;

  always #5 clock = ~clock;

  param_edit_ctrl #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
    .sel(sel), .min_or_max(min_or_max),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .wave_sel(wave_sel), .busy(busy)
  );

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (inc_pulse === 1'b1) begin
      n_inc <= n_inc + 1;
      inc_t.push_back(cyc);
    end
    if (dec_pulse === 1'b1) n_dec <= n_dec + 1;
    if (inc_pulse === 1'b1 && dec_pulse === 1'b1) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tk(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  // Strobes for a button debounced high for d ticks: one at the press, one HOLD ticks
  // later, then one every RPT ticks up to and including the release tick.
  function automatic int strobes(input int d);
    int s;
    s = 1;
    if (AR && d >= HOLD) s += 1 + (d - HOLD) / RPT;
    return s;
  endfunction

  task automatic apply(input bit up, input int cnt);
    if (m_sel == 0) m_wave = up ? (m_wave + cnt) % 4 : (m_wave - (cnt % 4) + 4) % 4;
  endtask

  task automatic check_op(input string tag, input int e_inc, input int e_dec,
                          input int bi, input int bd);
    chk({tag, ".inc_count"}, n_inc - bi, e_inc);
    chk({tag, ".dec_count"}, n_dec - bd, e_dec);
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".min_or_max"}, min_or_max, (m_sel == 3) ? 1 : 0);
    chk({tag, ".wave_sel"}, wave_sel, m_wave);
    chk({tag, ".busy_idle"}, busy, 0);
    chk({tag, ".no_overlap"}, both_seen, 0);
  endtask

  task automatic op_press(input bit up, input int ht);
    int bi, bd, c;
    bi = n_inc; bd = n_dec;
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    tk(ht * CLK_DIV);
    btn_up = 1'b0; btn_down = 1'b0;
    tk(SETTLE);
    c = strobes(ht);
    apply(up, c);
    check_op(up ? "press_up" : "press_down", up ? c : 0, up ? 0 : c, bi, bd);
  endtask

  task automatic op_mode(input int ht);
    int bi, bd;
    bi = n_inc; bd = n_dec;
    btn_mode = 1'b1;
    tk(ht * CLK_DIV);
    btn_mode = 1'b0;
    tk(SETTLE);
    m_sel = (m_sel + 1) % 4;
    check_op("mode", 0, 0, bi, bd);
  endtask

  task automatic op_both(input int ht);
    int bi, bd;
    bi = n_inc; bd = n_dec;
    btn_up = 1'b1; btn_down = 1'b1;
    tk(ht * CLK_DIV);
    btn_up = 1'b0; btn_down = 1'b0;
    tk(SETTLE);
    check_op("both", 0, 0, bi, bd);
  endtask

  // Up held, down joins after kt ticks and ends the session without any dec strobe.
  task automatic op_abort(input int kt, input int ht);
    int bi, bd, c;
    bi = n_inc; bd = n_dec;
    btn_up = 1'b1;
    tk(kt * CLK_DIV);
    btn_down = 1'b1;
    chk("abort.busy_before", busy, 1);
    tk(DEB * CLK_DIV + 4);
    chk("abort.busy_after_down", busy, 0);
    tk((ht - kt) * CLK_DIV - (DEB * CLK_DIV + 4));
    btn_up = 1'b0;
    tk(2);
    btn_down = 1'b0;
    tk(SETTLE);
    c = strobes(kt);
    apply(1'b1, c);
    check_op("abort", c, 0, bi, bd);
  endtask

  // Mode pressed while an up session is running must not change sel.
  task automatic op_upmode(input int ht);
    int bi, bd, c;
    bi = n_inc; bd = n_dec;
    btn_up = 1'b1;
    tk(2 * CLK_DIV);
    btn_mode = 1'b1;
    tk((DEB + 1) * CLK_DIV);
    btn_mode = 1'b0;
    tk((ht - DEB - 3) * CLK_DIV);
    btn_up = 1'b0;
    tk(SETTLE);
    c = strobes(ht);
    apply(1'b1, c);
    check_op("up_mode", c, 0, bi, bd);
  endtask

  initial begin
    tk(3);
    chk("reset.sel", sel, 0);
    chk("reset.min_or_max", min_or_max, 0);
    chk("reset.inc", inc_pulse, 0);
    chk("reset.dec", dec_pulse, 0);
    chk("reset.wave_sel", wave_sel, 0);
    chk("reset.busy", busy, 0);
    reset_n = 1'b1;
    tk(2 * CLK_DIV);

    // Bouncy press then a 40-tick hold.
    b_i = n_inc; b_d = n_dec; s0 = inc_t.size();
    btn_up = 1'b1; tk(1);
    btn_up = 1'b0; tk(1);
    btn_up = 1'b1; tk(1);
    btn_up = 1'b0; tk(1);
    btn_up = 1'b1;
    tk(40 * CLK_DIV);
    btn_up = 1'b0;
    tk(SETTLE);
    n = strobes(40);
    apply(1'b1, n);
    check_op("bounce", n, 0, b_i, b_d);
    first_ok = 1;
    if (inc_t.size() >= s0 + 2)
      first_ok = ((inc_t[s0+1] - inc_t[s0] > (HOLD - 1) * CLK_DIV) &&
                  (inc_t[s0+1] - inc_t[s0] <= HOLD * CLK_DIV)) ? 1 : 0;
    bad = 0;
    for (int i = s0 + 2; i < inc_t.size(); i++)
      if (inc_t[i] - inc_t[i-1] != RPT * CLK_DIV) bad++;
    chk("bounce.first_gap", first_ok, 1);
    chk("bounce.repeat_gaps", bad, 0);

    for (int i = 0; i < 4; i++) op_mode(DEB + 1);

    for (int i = 0; i < 3; i++) op_press(1'b0, DEB + 1);
    op_press(1'b0, DEB + 1);
    op_press(1'b0, DEB + 2);
    op_press(1'b1, DEB + 1);

    op_abort(12, 12 + DEB + 2);
    op_press(1'b0, 40);
    op_upmode(DEB + 6);
    op_both(DEB + 2);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: op_press(1'b1, $urandom_range(DEB, 30));
        1: op_press(1'b0, $urandom_range(DEB, 30));
        2: op_mode($urandom_range(DEB, 6));
        3: op_both($urandom_range(DEB, 10));
        4: begin
          k = $urandom_range(DEB + 1, 14);
          op_abort(k, k + DEB + 2 + $urandom_range(0, 5));
        end
        default: op_upmode($urandom_range(DEB + 3, 25));
      endcase
    end

    // Reset in the middle of a held session, button still down afterwards.
    if (m_sel == 0) op_mode(DEB + 1);
    btn_up = 1'b1;
    tk(20 * CLK_DIV);
    chk("midreset.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midreset.sel", sel, 0);
    chk("midreset.min_or_max", min_or_max, 0);
    chk("midreset.inc", inc_pulse, 0);
    chk("midreset.dec", dec_pulse, 0);
    chk("midreset.wave_sel", wave_sel, 0);
    chk("midreset.busy", busy, 0);
    tk(3);
    reset_n = 1'b1;
    m_sel = 0; m_wave = 0;
    b_i = n_inc; b_d = n_dec;
    tk(15 * CLK_DIV);
    btn_up = 1'b0;
    tk(SETTLE);
    n = strobes(15);
    apply(1'b1, n);
    check_op("after_reset", n, 0, b_i, b_d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_edit_ctrl.md
PARAM_EDIT_CTRL -- requirements
Module: param_edit_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning system clocks per sample tick (tick = 1 kHz at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 20, meaning ticks a synchronized button must be stable before its debounced level changes.
REQ-003 SHALL have parameter HOLD_TICKS, default 500, meaning ticks from first strobe to first auto-repeat strobe.
REQ-004 SHALL have parameter REPEAT_TICKS, default 250, meaning ticks between subsequent auto-repeat strobes.
REQ-005 SHALL have port clock, input, 1, system clock; all flops on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports btn_up, btn_down, btn_mode, input, 1 each, raw asynchronous push-buttons, active-high.
REQ-008 SHALL have port sel, output, 2, edited parameter: 0 WAVE, 1 FREQ, 2 MIN, 3 MAX.
REQ-009 SHALL have port min_or_max, output, 1, high iff sel==MAX, for direct connection to the amplitude-limit register block.
REQ-010 SHALL have ports inc_pulse, dec_pulse, output, 1 each, single-clock strobes for the selected parameter.
REQ-011 SHALL have port wave_sel, output, 2, current waveform index 0..3.
REQ-012 SHALL have port busy, output, 1, high whenever the repeat FSM is not IDLE.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a debouncer sampled only on tick.
REQ-014 SHALL generate tick as a one-clock pulse every CLK_DIV clocks from a free-running counter wrapping at CLK_DIV-1.
REQ-015 SHALL run repeat FSM states IDLE, FIRST, HOLD, REPEAT.
REQ-016 IDLE -> FIRST on debounced rising edge of exactly one of up/down; direction latched at that edge.
REQ-017 FIRST SHALL emit one strobe (inc_pulse or dec_pulse) in the clock after the edge, load counter with HOLD_TICKS, go to HOLD.
REQ-018 HOLD SHALL decrement counter per tick; at zero emit strobe, load REPEAT_TICKS, go to REPEAT.
REQ-019 REPEAT SHALL decrement per tick; at zero emit strobe and reload REPEAT_TICKS.
REQ-020 FIRST/HOLD/REPEAT SHALL return to IDLE, without a strobe, in the clock after the latched button debounces low or the opposite button debounces high.
REQ-021 Both up and down debounced high in IDLE: no strobe, stay IDLE until both released.
REQ-022 inc_pulse and dec_pulse SHALL never be high in the same clock.
REQ-023 Debounced rising edge of btn_mode in IDLE SHALL advance sel 0->1->2->3->0 (wrap) in the next clock; mode edges outside IDLE SHALL be discarded.
REQ-024 When sel==WAVE, each strobe SHALL also update wave_sel modulo 4 (inc 3->0, dec 0->3); other sel values SHALL leave wave_sel unchanged.
REQ-025 sel, min_or_max, wave_sel, busy SHALL be registered outputs; strobes SHALL be registered one-clock pulses.

Reset
REQ-026 reset_n low SHALL immediately force sel=0, min_or_max=0, inc_pulse=0, dec_pulse=0, wave_sel=0, busy=0, FSM=IDLE, all counters and debounced levels=0.
REQ-027 Reset asserted mid-hold SHALL abort without strobe; a button still held after reset release SHALL be treated as a new press once debounced.

Configuration
REQ-028 With AUTO_REPEAT_EN defined SHALL implement HOLD/REPEAT as above.
REQ-029 Without AUTO_REPEAT_EN SHALL go FIRST -> HOLD and stay there without strobes until release (one strobe per press); HOLD_TICKS/REPEAT_TICKS unused.

Structure
REQ-030 Package fg_ctrl_pkg SHALL hold the sel encoding constants (SEL_WAVE..SEL_MAX) and the repeat-FSM state typedef.
REQ-031 Sub-module btn_debounce (synchronizer + tick-sampled stability counter, outputs level and rise pulse) SHALL be instantiated three times.

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=8, REPEAT_TICKS=2, AUTO_REPEAT_EN defined)
REQ-032 Bounce btn_up 5 times within 2 ticks, then hold 40 ticks -> exactly one inc_pulse at debounce, then pulses 8 ticks later and every 2 ticks; none after release.
REQ-033 Four btn_mode presses -> sel 1,2,3,0; min_or_max high only while sel==3.
REQ-034 sel=0, three dec presses -> wave_sel 3,2,1; inc press at 3 -> 0.
REQ-035 Hold btn_up, press btn_down during HOLD -> strobes stop, busy low within one clock of down debouncing; no dec_pulse.
REQ-036 Assert reset_n low during REPEAT with btn_up held -> all outputs 0 immediately; after release, new inc_pulse after debounce.
REQ-037 Rebuild without AUTO_REPEAT_EN, hold btn_down 40 ticks -> exactly one dec_pulse.
